// File: rtl/rv32_pkg.sv
// Shared types and constants for the RV32 program-counter sequencer.
// Holds the FSM state encoding, trap cause codes and small helper functions.
package rv32_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'b00,
        FETCH_WAIT = 2'b01,
        EXEC       = 2'b10,
        TRAP       = 2'b11
    } pc_state_t;

    typedef logic [1:0] trap_cause_t;

    localparam trap_cause_t TRAP_NONE      = 2'b00;
    localparam trap_cause_t TRAP_MISALIGN  = 2'b01;
    localparam trap_cause_t TRAP_FETCH_TMO = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction fetch targets must be word aligned.
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            return v;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection (JALR > JAL > taken branch > sequential)
// plus the misaligned-target flag for the selected address.
module pc_next_sel
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            pc_src,
    input  logic            jal,
    input  logic            jalr,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(3'd4);
    localparam logic [XLEN-1:0] CLR_BIT0  = ~(XLEN'(1'b1));

    // Priority mux; pc_src only matters when neither jump is decoded.
    always_comb begin
        next_pc = pc + PC_STEP;
        if (jalr) begin
            next_pc = (rs1_data + imm) & CLR_BIT0;
        end else if (jal || pc_src) begin
            next_pc = pc + imm;
        end else begin
            next_pc = pc + PC_STEP;
        end
        misaligned = addr_misaligned(next_pc[1:0]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch request/grant, fetch wait with timeout,
// execute and PC update, sticky trap. Optional counters under `PC_STATS_EN`.
module pc_sequencer
    import rv32_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int              FETCH_TMO = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_src,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            exec_done,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            instr_valid,
    output logic            trap,
    output logic [1:0]      trap_cause
`ifdef PC_STATS_EN
    ,
    input  logic            is_branch,
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_not_taken,
    output logic [31:0]     stat_jumps
`endif
);

    localparam int                CNT_W    = (FETCH_TMO > 1) ? $clog2(FETCH_TMO) : 1;
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(FETCH_TMO - 1);
    localparam logic [XLEN-1:0]   PC_STEP  = XLEN'(3'd4);

    pc_state_t        state_r;
    logic [XLEN-1:0]  pc_r;
    logic             imem_req_r;
    logic             instr_valid_r;
    logic             trap_r;
    trap_cause_t      trap_cause_r;
    logic [CNT_W-1:0] tmo_cnt_r;

    logic [XLEN-1:0]  next_pc_s;
    logic             misaligned_s;

    pc_next_sel #(
        .XLEN       (XLEN)
    ) u_next_sel (
        .pc         (pc_r),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .pc_src     (pc_src),
        .jal        (jal),
        .jalr       (jalr),
        .next_pc    (next_pc_s),
        .misaligned (misaligned_s)
    );

    // Sequencer FSM. imem_req comes up one cycle after reset, then is
    // re-armed on every EXEC exit so the steady-state rate is 3 cycles/instr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= FETCH_REQ;
            pc_r          <= RESET_PC;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            trap_r        <= 1'b0;
            trap_cause_r  <= TRAP_NONE;
            tmo_cnt_r     <= '0;
        end else begin
            instr_valid_r <= 1'b0;
            case (state_r)
                FETCH_REQ: begin
                    if (imem_req_r && imem_gnt) begin
                        state_r    <= FETCH_WAIT;
                        imem_req_r <= 1'b0;
                        tmo_cnt_r  <= '0;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        state_r       <= EXEC;
                        instr_valid_r <= 1'b1;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_r      <= TRAP;
                        trap_r       <= 1'b1;
                        trap_cause_r <= TRAP_FETCH_TMO;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + CNT_W'(1'b1);
                    end
                end
                EXEC: begin
                    if (exec_done && misaligned_s) begin
                        state_r      <= TRAP;
                        trap_r       <= 1'b1;
                        trap_cause_r <= TRAP_MISALIGN;
                    end else if (exec_done) begin
                        pc_r       <= next_pc_s;
                        state_r    <= FETCH_REQ;
                        imem_req_r <= 1'b1;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                TRAP: begin
                    imem_req_r <= 1'b0;
                end
                default: begin
                    state_r    <= TRAP;
                    imem_req_r <= 1'b0;
                    trap_r     <= 1'b1;
                end
            endcase
        end
    end

`ifdef PC_STATS_EN
    logic [31:0] stat_taken_r;
    logic [31:0] stat_not_taken_r;
    logic [31:0] stat_jumps_r;

    // Retirement counters, bumped only on a successful PC update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_taken_r     <= 32'd0;
            stat_not_taken_r <= 32'd0;
            stat_jumps_r     <= 32'd0;
        end else if (state_r == EXEC && exec_done && !misaligned_s) begin
            if (pc_src && !jal && !jalr) begin
                stat_taken_r <= sat_inc32(stat_taken_r);
            end else begin
                stat_taken_r <= stat_taken_r;
            end
            if (jal || jalr) begin
                stat_jumps_r <= sat_inc32(stat_jumps_r);
            end else begin
                stat_jumps_r <= stat_jumps_r;
            end
            if (is_branch && !pc_src) begin
                stat_not_taken_r <= sat_inc32(stat_not_taken_r);
            end else begin
                stat_not_taken_r <= stat_not_taken_r;
            end
        end else begin
            stat_taken_r     <= stat_taken_r;
            stat_not_taken_r <= stat_not_taken_r;
            stat_jumps_r     <= stat_jumps_r;
        end
    end

    assign stat_taken     = stat_taken_r;
    assign stat_not_taken = stat_not_taken_r;
    assign stat_jumps     = stat_jumps_r;
`endif

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_r + PC_STEP;
    assign instr_valid = instr_valid_r;
    assign trap        = trap_r;
    assign trap_cause  = trap_cause_r;

endmodule
